// File: rtl/xbar_config_loader_if.sv
// Configuration stream and committed-select bundle for xbar_config_loader.
// The master side (config source) drives start/valid/sel. The slave side
// (the loader) returns ready/busy/done/err and the packed mux select bus.
interface xbar_config_loader_if #(
  parameter int NUM_OUT = 28,
  parameter int SEL_W   = 5
);
  logic                     io_cfg_start;
  logic                     io_cfg_valid;
  logic                     io_cfg_ready;
  logic [SEL_W-1:0]         io_cfg_sel;
  logic [NUM_OUT*SEL_W-1:0] io_mux_configs;
  logic                     io_cfg_busy;
  logic                     io_cfg_done;
  logic                     io_cfg_err;

  modport master (
    output io_cfg_start,
    output io_cfg_valid,
    output io_cfg_sel,
    input  io_cfg_ready,
    input  io_mux_configs,
    input  io_cfg_busy,
    input  io_cfg_done,
    input  io_cfg_err
  );

  modport slave (
    input  io_cfg_start,
    input  io_cfg_valid,
    input  io_cfg_sel,
    output io_cfg_ready,
    output io_mux_configs,
    output io_cfg_busy,
    output io_cfg_done,
    output io_cfg_err
  );
endinterface

// File: rtl/xbar_config_loader.sv
// xbar_config_loader: configuration front end for the LUT-tile input crossbar.
// Select values arrive one per beat into a shadow register. Once all NUM_OUT
// fields are written, the shadow is copied to the committed mux select bus in
// a single cycle, so the crossbar never sees a partial configuration.
//
// Optional feature macro: XBAR_CFG_RANGE_CHECK_EN
//   defined   - selects >= NUM_IN set a sticky error flag, and a load that
//               carries the flag does not update the committed selects.
//   undefined - the error output is tied low and every load commits.
//
// Reset is synchronous and active-low (reset == 0 clears all state).
module xbar_config_loader #(
  parameter int NUM_IN  = 24,
  parameter int NUM_OUT = 28,
  parameter int SEL_W   = 5
) (
  input logic                 clk,
  input logic                 reset,
  xbar_config_loader_if.slave cfg
);

  localparam int IDX_W = $clog2(NUM_OUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // True when a select value addresses a crossbar input that does not exist.
  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel);
    logic [SEL_W:0] sel_ext;
    sel_ext = {1'b0, sel};
    return (sel_ext >= (SEL_W + 1)'(NUM_IN));
  endfunction

  state_e                          state_r;
  state_e                          state_nx_s;
  logic [IDX_W-1:0]                idx_r;
  logic [NUM_OUT-1:0][SEL_W-1:0]   shadow_r;
  logic [NUM_OUT-1:0][SEL_W-1:0]   mux_configs_r;
  logic                            ready_r;
  logic                            busy_r;
  logic                            done_r;
  logic                            err_r;

  logic                            beat_take_s;
  logic                            clear_load_s;
  logic                            write_beat_s;
  logic                            commit_s;

  // Beat handshake; ready_r mirrors "state is LOAD", so it never depends on valid.
  assign beat_take_s = cfg.io_cfg_valid && ready_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_nx_s   = state_r;
    clear_load_s = 1'b0;
    write_beat_s = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg.io_cfg_start) begin
          state_nx_s   = ST_LOAD;
          clear_load_s = 1'b1;
        end else begin
          state_nx_s   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cfg.io_cfg_start) begin
          // Restart: index and error clear, a beat in this cycle is dropped.
          state_nx_s   = ST_LOAD;
          clear_load_s = 1'b1;
        end else if (beat_take_s) begin
          write_beat_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_nx_s = ST_COMMIT;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s   = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        // Start is ignored here; the commit always completes.
        state_nx_s = ST_IDLE;
        commit_s   = 1'b1;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Beat index counter: cleared on (re)entry to LOAD, advances per written beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_r <= '0;
    end else if (clear_load_s) begin
      idx_r <= '0;
    end else if (write_beat_s) begin
      idx_r <= idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Shadow register: one field written per accepted beat, never cleared by restart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_r <= '0;
    end else if (write_beat_s) begin
      shadow_r[idx_r] <= cfg.io_cfg_sel;
    end else begin
      shadow_r <= shadow_r;
    end
  end

`ifdef XBAR_CFG_RANGE_CHECK_EN
  // Sticky range error, cleared only by start or reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (clear_load_s) begin
      err_r <= 1'b0;
    end else if (write_beat_s && sel_out_of_range(cfg.io_cfg_sel)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  // Range checking is compiled out; selects pass through unchecked.
  always_comb begin
    err_r = 1'b0;
  end
`endif

  // Atomic commit of the shadow to the crossbar select bus, unless a bad select was seen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mux_configs_r <= '0;
    end else if (commit_s && !err_r) begin
      mux_configs_r <= shadow_r;
    end else begin
      mux_configs_r <= mux_configs_r;
    end
  end

  // Registered status flags, decoded from the next state so they align with state_r.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_nx_s == ST_LOAD);
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= commit_s;
    end
  end

  assign cfg.io_cfg_ready   = ready_r;
  assign cfg.io_cfg_busy    = busy_r;
  assign cfg.io_cfg_done    = done_r;
  assign cfg.io_cfg_err     = err_r;
  assign cfg.io_mux_configs = mux_configs_r;

endmodule
